// File: rtl/mmio_timer_resp.sv
// Memory-mapped 9-bit prescaled countdown timer with a sticky expiry flag and interrupt.
// It decodes ADDR[8:7]==BASE and returns read data with one cycle of latency.
module mmio_timer_resp #(
  parameter int unsigned PRESCALE = 8,
  parameter logic [1:0]  BASE     = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic [8:0] wdata,
  input  logic       w,
  output logic [8:0] rdata,
  output logic       rd_hit,
  output logic       irq,
  output logic       tick
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {STOP, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           en, ar, ie, flag;
  logic           en_nxt, ar_nxt, ie_nxt, flag_nxt;
  logic [8:0]     load, load_nxt;
  logic [8:0]     count, count_nxt;
  logic [PW-1:0]  presc, presc_nxt;
  logic [8:0]     rd_val;
  logic           sel, wr_ctrl, wr_load, wr_status;
  logic           unused_addr;

  assign sel         = (addr[8:7] == BASE);
  assign wr_ctrl     = w && sel && (addr[1:0] == 2'd0);
  assign wr_load     = w && sel && (addr[1:0] == 2'd1);
  assign wr_status   = w && sel && (addr[1:0] == 2'd3);
  assign unused_addr = ^addr[6:2];

  assign tick = (state == RUN) && (presc == PW'(PRESCALE - 1));
  assign irq  = flag & ie;

  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    ar_nxt    = ar;
    ie_nxt    = ie;
    flag_nxt  = flag;
    load_nxt  = load;
    count_nxt = count;
    presc_nxt = '0;

    if (wr_status && wdata[0]) flag_nxt = 1'b0;
    if (wr_load) load_nxt = wdata;

    case (state)
      STOP: begin
        if (wr_load) count_nxt = wdata;
        if (wr_ctrl && wdata[0]) state_nxt = RUN;
      end
      RUN: begin
        presc_nxt = tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (count != '0) begin
            count_nxt = count - 1'b1;
          end else begin
            // hardware set is evaluated after the W1C clear so it takes priority
            flag_nxt = 1'b1;
            if (ar) begin
              count_nxt = load;
            end else begin
              state_nxt = DONE;
              en_nxt    = 1'b0;
            end
          end
        end
        if (wr_ctrl) state_nxt = wdata[0] ? RUN : STOP;
      end
      DONE: begin
        if (wr_load) count_nxt = wdata;
        if (wr_ctrl && wdata[0]) state_nxt = RUN;
      end
      default: state_nxt = STOP;
    endcase

    // a software CTRL write overrides the hardware EN clear on expiry
    if (wr_ctrl) begin
      en_nxt = wdata[0];
      ar_nxt = wdata[1];
      ie_nxt = wdata[2];
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr[1:0])
      2'd0: rd_val = {6'b0, ie, ar, en};
      2'd1: rd_val = load;
      2'd2: rd_val = count;
      2'd3: rd_val = {8'b0, flag};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STOP;
      en     <= 1'b0;
      ar     <= 1'b0;
      ie     <= 1'b0;
      flag   <= 1'b0;
      load   <= '0;
      count  <= '0;
      presc  <= '0;
      rdata  <= '0;
      rd_hit <= 1'b0;
    end else begin
      state  <= state_nxt;
      en     <= en_nxt;
      ar     <= ar_nxt;
      ie     <= ie_nxt;
      flag   <= flag_nxt;
      load   <= load_nxt;
      count  <= count_nxt;
      presc  <= presc_nxt;
      rdata  <= sel ? rd_val : '0;
      rd_hit <= sel;
    end
  end

endmodule

// File: tb/tb_mmio_timer_resp.sv
// Directed bench for mmio_timer_resp (PRESCALE=4); read results go through a scoreboard queue.
module tb_mmio_timer_resp;

  logic       clk;
  logic       rst;
  logic [8:0] addr;
  logic [8:0] wdata;
  logic       w;
  logic [8:0] rdata;
  logic       rd_hit;
  logic       irq;
  logic       tick;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc_n = 0;
  int unsigned t0;

  logic [8:0] exp_q[$];
  logic       hit_q[$];
  string      tag_q[$];

  localparam logic [8:0] A_CTRL   = 9'h100;
  localparam logic [8:0] A_LOAD   = 9'h101;
  localparam logic [8:0] A_COUNT  = 9'h102;
  localparam logic [8:0] A_STATUS = 9'h103;
  localparam logic [8:0] A_IDLE   = 9'h000;

  mmio_timer_resp #(.PRESCALE(4), .BASE(2'b10)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .w      (w),
    .rdata  (rdata),
    .rd_hit (rd_hit),
    .irq    (irq),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [8:0] d);
    addr  = a;
    wdata = d;
    w     = 1'b1;
    step();
    w     = 1'b0;
    addr  = A_IDLE;
  endtask

  // issue a read, queue its expectation, compare when the data appears next cycle
  task automatic bus_read(input logic [8:0] a, input logic [8:0] e, input logic h, input string tag);
    logic [8:0] ev;
    logic       eh;
    string      et;
    addr = a;
    w    = 1'b0;
    exp_q.push_back(e);
    hit_q.push_back(h);
    tag_q.push_back(tag);
    step();
    addr = A_IDLE;
    ev = exp_q.pop_front();
    eh = hit_q.pop_front();
    et = tag_q.pop_front();
    chk({et, "_rdata"}, rdata, ev);
    chk({et, "_hit"}, 9'(rd_hit), 9'(eh));
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc_n < target) step();
  endtask

  initial begin
    rst   = 1'b1;
    addr  = A_IDLE;
    wdata = '0;
    w     = 1'b0;

    // 1: reset and idle reads
    step();
    step();
    chk("rst_rdata", rdata, 9'h000);
    chk("rst_hit", 9'(rd_hit), 9'h000);
    chk("rst_irq", 9'(irq), 9'h000);
    chk("rst_tick", 9'(tick), 9'h000);
    rst = 1'b0;
    bus_read(A_CTRL,   9'h000, 1'b1, "rst_ctrl");
    bus_read(A_LOAD,   9'h000, 1'b1, "rst_load");
    bus_read(A_COUNT,  9'h000, 1'b1, "rst_count");
    bus_read(A_STATUS, 9'h000, 1'b1, "rst_status");

    // 2: one-shot, LOAD=3, IE=1
    bus_write(A_LOAD, 9'd3);
    bus_write(A_CTRL, 9'h005);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("os_tick_k%0d", k), 9'(tick), 9'((k % 4) == 3));
      chk($sformatf("os_irq_k%0d", k), 9'(irq), 9'h000);
      bus_read(A_COUNT, 9'(3 - k / 4), 1'b1, $sformatf("os_cnt_k%0d", k));
    end
    chk("os_irq_done", 9'(irq), 9'h001);
    chk("os_tick_done", 9'(tick), 9'h000);
    bus_read(A_CTRL,   9'h004, 1'b1, "os_ctrl");
    bus_read(A_STATUS, 9'h001, 1'b1, "os_status");
    bus_read(A_COUNT,  9'h000, 1'b1, "os_count");

    // 3: auto-reload, LOAD=2, IE=0
    bus_write(A_STATUS, 9'h001);
    chk("ar_irq_cleared", 9'(irq), 9'h000);
    bus_write(A_LOAD, 9'd2);
    bus_write(A_CTRL, 9'h003);
    t0 = cyc_n;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("ar_tick_k%0d", k), 9'(tick), 9'((k % 4) == 3));
      bus_read(A_COUNT, 9'(2 - (k % 12) / 4), 1'b1, $sformatf("ar_cnt_k%0d", k));
    end
    bus_read(A_STATUS, 9'h001, 1'b1, "ar_status");
    bus_read(A_CTRL,   9'h003, 1'b1, "ar_ctrl");
    chk("ar_irq", 9'(irq), 9'h000);

    // 4: W1C racing the hardware set, then one cycle after it
    bus_write(A_STATUS, 9'h001);
    wait_until(t0 + 35);
    bus_write(A_STATUS, 9'h001);
    bus_read(A_STATUS, 9'h001, 1'b1, "w1c_same_cycle");
    bus_write(A_STATUS, 9'h001);
    bus_read(A_STATUS, 9'h000, 1'b1, "w1c_cleared");
    wait_until(t0 + 48);
    bus_write(A_STATUS, 9'h001);
    bus_read(A_STATUS, 9'h000, 1'b1, "w1c_next_cycle");

    // 5: writes to other regions are ignored
    bus_write(9'h041, 9'h1FF);
    bus_write(9'h0C1, 9'h1FF);
    bus_read(A_LOAD, 9'd2, 1'b1, "oreg_load");
    bus_read(9'h041, 9'h000, 1'b0, "oreg_ram");

    // 6: reset mid-run with a write pending
    bus_write(A_CTRL, 9'h000);
    bus_write(A_LOAD, 9'd5);
    bus_write(A_CTRL, 9'h001);
    bus_read(A_COUNT, 9'd5, 1'b1, "mid_count5");
    rst   = 1'b1;
    addr  = A_CTRL;
    wdata = 9'h007;
    w     = 1'b1;
    step();
    rst  = 1'b0;
    w    = 1'b0;
    addr = A_IDLE;
    chk("mid_tick", 9'(tick), 9'h000);
    chk("mid_irq", 9'(irq), 9'h000);
    chk("mid_hit", 9'(rd_hit), 9'h000);
    chk("mid_rdata", rdata, 9'h000);
    bus_read(A_COUNT,  9'h000, 1'b1, "mid_count");
    bus_read(A_CTRL,   9'h000, 1'b1, "mid_ctrl");
    bus_read(A_LOAD,   9'h000, 1'b1, "mid_load");
    bus_read(A_STATUS, 9'h000, 1'b1, "mid_status");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid_stop_tick_k%0d", k), 9'(tick), 9'h000);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
